// File: rtl/instr_queue_param.sv
// Parametrised circular-buffer instruction queue sitting between decode and
// dispatch. Decode appends packed instruction words with a valid/ready
// handshake; dispatch sees the head word combinationally (first-word
// fall-through) and consumes it with its own valid/ready handshake.
// A flush discards every queued entry without touching the storage array.
// Occupancy, almost-full and peak-occupancy status are all derived from
// registered state, so they are glitch-free relative to clk.
module instr_queue_param #(
    parameter int INSTR_W   = 76,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = 6,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enq_valid,
    input  logic [INSTR_W-1:0] enq_instr,
    output logic               enq_ready,
    output logic               deq_valid,
    output logic [INSTR_W-1:0] deq_instr,
    input  logic               deq_ready,
    input  logic               flush,
    output logic [CNT_W-1:0]   count,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               stall_out,
    output logic [CNT_W-1:0]   peak_count
);

    // DEPTH is a power of two, so pointers wrap naturally when they overflow.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_peak;

    logic               w_full;
    logic               w_empty;
    logic               w_enqFire;
    logic               w_deqFire;
    logic [CNT_W-1:0]   w_nextCount;

    // Status is decoded purely from the registered count. In particular the
    // ready towards decode never looks at deq_ready, so a dequeue on a full
    // queue does not open a slot in the same cycle.
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_enqFire   = enq_valid & ~w_full;
    assign w_deqFire   = deq_ready & ~w_empty;

    assign full        = w_full;
    assign empty       = w_empty;
    assign enq_ready   = ~w_full;
    assign deq_valid   = ~w_empty;
    assign stall_out   = w_full;
    assign almost_full = (r_count >= AF_CNT);
    assign count       = r_count;
    assign peak_count  = r_peak;

    // First-word fall-through: the head entry is visible without a read cycle.
    assign deq_instr   = r_mem[r_rdPtr];

    // Next occupancy: flush empties the queue and overrides both fire events;
    // a simultaneous enqueue and dequeue leave the occupancy unchanged.
    always_comb begin
        w_nextCount = r_count;
        if (flush) begin
            w_nextCount = '0;
        end else if (w_enqFire && !w_deqFire) begin
            w_nextCount = r_count + CNT_ONE;
        end else if (w_deqFire && !w_enqFire) begin
            w_nextCount = r_count - CNT_ONE;
        end
    end

    // Pointer, occupancy and peak tracking; the peak survives a flush and
    // only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_peak  <= '0;
        end else begin
            r_count <= w_nextCount;
            if (flush) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_enqFire) begin
                    r_wrPtr <= r_wrPtr + PTR_ONE;
                end
                if (w_deqFire) begin
                    r_rdPtr <= r_rdPtr + PTR_ONE;
                end
            end
            if (w_nextCount > r_peak) begin
                r_peak <= w_nextCount;
            end
        end
    end

    // Storage array: cleared on reset so the head output is never X, left
    // untouched by flush, written at the tail on an accepted enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_enqFire && !flush) begin
            r_mem[r_wrPtr] <= enq_instr;
        end
    end

endmodule

// File: tb/tb_instr_queue_param.sv
// Self-checking bench for instr_queue_param. A queue-based model of the
// instruction queue is advanced once per clock edge from the same inputs the
// DUT sees; a compare process checks every output against it on each falling
// edge, and a few literal expectations pin the model in the directed tests.
module tb_instr_queue_param;

    localparam int INSTR_W   = 76;
    localparam int DEPTH     = 8;
    localparam int AF_THRESH = 6;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               enqValid = 1'b0;
    logic [INSTR_W-1:0] enqInstr = '0;
    logic               enqReady;
    logic               deqValid;
    logic [INSTR_W-1:0] deqInstr;
    logic               deqReady = 1'b0;
    logic               flush = 1'b0;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               almostFull;
    logic               stallOut;
    logic [CNT_W-1:0]   peakCount;

    logic [INSTR_W-1:0] modelQ[$];
    int                 modelPeak = 0;
    bit                 checkEn = 1'b0;
    int                 checksTotal = 0;
    int                 checksPassed = 0;

    instr_queue_param #(
        .INSTR_W(INSTR_W),
        .DEPTH(DEPTH),
        .AF_THRESH(AF_THRESH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enq_valid(enqValid),
        .enq_instr(enqInstr),
        .enq_ready(enqReady),
        .deq_valid(deqValid),
        .deq_instr(deqInstr),
        .deq_ready(deqReady),
        .flush(flush),
        .count(count),
        .full(full),
        .empty(empty),
        .almost_full(almostFull),
        .stall_out(stallOut),
        .peak_count(peakCount)
    );

    always #5 clk = ~clk;

    // One comparison: tally it and report a mismatch.
    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checksTotal++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the model across the edge.
    task automatic applyStimulus(input logic r, input logic f, input logic ev,
                                 input logic [INSTR_W-1:0] ei, input logic dr);
        bit doEnq;
        bit doDeq;
        @(negedge clk);
        rst      = r;
        flush    = f;
        enqValid = ev;
        enqInstr = ei;
        deqReady = dr;
        @(posedge clk);
        if (r) begin
            modelQ.delete();
            modelPeak = 0;
        end else if (f) begin
            modelQ.delete();
        end else begin
            doDeq = dr && (modelQ.size() > 0);
            doEnq = ev && (modelQ.size() < DEPTH);
            if (doDeq) void'(modelQ.pop_front());
            if (doEnq) modelQ.push_back(ei);
        end
        if (modelQ.size() > modelPeak) modelPeak = modelQ.size();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic enq(input logic [INSTR_W-1:0] w);
        applyStimulus(1'b0, 1'b0, 1'b1, w, 1'b0);
    endtask

    task automatic deq();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
    endtask

    // Model-vs-DUT comparison on every falling edge once reset has been applied.
    always @(negedge clk) begin
        int sz;
        if (checkEn) begin
            sz = modelQ.size();
            checkOutput("count", 128'(count), 128'(sz));
            checkOutput("full", 128'(full), 128'(sz == DEPTH));
            checkOutput("empty", 128'(empty), 128'(sz == 0));
            checkOutput("almost_full", 128'(almostFull), 128'(sz >= AF_THRESH));
            checkOutput("enq_ready", 128'(enqReady), 128'(sz != DEPTH));
            checkOutput("deq_valid", 128'(deqValid), 128'(sz != 0));
            checkOutput("stall_out", 128'(stallOut), 128'(sz == DEPTH));
            checkOutput("peak_count", 128'(peakCount), 128'(modelPeak));
            if (sz > 0) begin
                checkOutput("deq_instr", 128'(deqInstr), 128'(modelQ[0]));
            end
        end
    end

    initial begin
        int enqPct;
        int deqPct;
        logic [INSTR_W-1:0] w;

        // Reset and check the documented reset values literally.
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 1'b0);
        #1;
        checkOutput("reset count", 128'(count), 128'd0);
        checkOutput("reset deq_instr", 128'(deqInstr), 128'd0);
        checkOutput("reset empty", 128'(empty), 128'd1);
        checkOutput("reset enq_ready", 128'(enqReady), 128'd1);
        checkOutput("reset almost_full", 128'(almostFull), 128'd0);
        checkOutput("reset peak", 128'(peakCount), 128'd0);
        checkEn = 1'b1;
        idle();

        // Fill with 0x1..0x8; almost_full from the 6th entry onward.
        $display("[TB] fill");
        for (int i = 1; i <= 8; i++) begin
            enq(INSTR_W'(i));
            #1;
            checkOutput("fill almost_full", 128'(almostFull), 128'(i >= 6));
        end
        checkOutput("fill full", 128'(full), 128'd1);
        checkOutput("fill stall", 128'(stallOut), 128'd1);
        checkOutput("fill peak", 128'(peakCount), 128'd8);

        // Drain in order.
        $display("[TB] drain");
        for (int i = 1; i <= 8; i++) begin
            #1;
            checkOutput("drain order", 128'(deqInstr), 128'(i));
            deq();
        end
        #1;
        checkOutput("drain empty", 128'(empty), 128'd1);

        // Wrap-around: 5 in, 5 out, 6 in, 6 out.
        $display("[TB] wrap");
        for (int i = 0; i < 5; i++) enq(INSTR_W'(32'h10 + i));
        for (int i = 0; i < 5; i++) deq();
        for (int i = 0; i < 6; i++) enq(INSTR_W'(32'h20 + i));
        for (int i = 0; i < 6; i++) deq();

        // Simultaneous enqueue/dequeue at count 3.
        $display("[TB] streaming");
        for (int i = 0; i < 3; i++) enq(INSTR_W'(32'h90 + i));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, INSTR_W'(32'hA0 + i), 1'b1);
            #1;
            checkOutput("stream count", 128'(count), 128'd3);
        end
        for (int i = 0; i < 3; i++) deq();

        // Full with enqueue and dequeue together: head leaves, word refused.
        $display("[TB] full both");
        for (int i = 0; i < 8; i++) enq(INSTR_W'(32'hB0 + i));
        applyStimulus(1'b0, 1'b0, 1'b1, INSTR_W'(32'hC0), 1'b1);
        #1;
        checkOutput("full both count", 128'(count), 128'd7);
        checkOutput("full both head", 128'(deqInstr), 128'h B1);

        // Flush at count 5 with enqueue and dequeue requested.
        $display("[TB] flush");
        deq();
        deq();
        applyStimulus(1'b0, 1'b1, 1'b1, INSTR_W'(32'hEE), 1'b1);
        #1;
        checkOutput("flush count", 128'(count), 128'd0);
        checkOutput("flush empty", 128'(empty), 128'd1);
        checkOutput("flush peak", 128'(peakCount), 128'd8);
        enq(INSTR_W'(32'h55));
        #1;
        checkOutput("post flush head", 128'(deqInstr), 128'h55);
        checkOutput("post flush valid", 128'(deqValid), 128'd1);
        deq();

        // Randomised traffic with phases biased towards filling or draining,
        // plus occasional flushes and resets.
        $display("[TB] random");
        enqPct = 50;
        deqPct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 150 == 0) begin
                enqPct = $urandom_range(10, 95);
                deqPct = $urandom_range(10, 95);
            end
            w = {$urandom, $urandom, $urandom};
            applyStimulus($urandom_range(0, 399) == 0,
                          $urandom_range(0, 59) == 0,
                          $urandom_range(0, 99) < enqPct,
                          w,
                          $urandom_range(0, 99) < deqPct);
        end

        // Reset mid-stream discards everything and clears the peak.
        for (int i = 0; i < 4; i++) enq(INSTR_W'(32'h300 + i));
        applyStimulus(1'b1, 1'b0, 1'b1, INSTR_W'(32'h3FF), 1'b1);
        #1;
        checkOutput("midreset count", 128'(count), 128'd0);
        checkOutput("midreset peak", 128'(peakCount), 128'd0);
        checkOutput("midreset deq_instr", 128'(deqInstr), 128'd0);
        idle();
        idle();

        checkEn = 1'b0;
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
